// File: rtl/usb_wire_pkg.sv
// rtl/usb_wire_pkg.sv - line symbol codes, FIFO entry layout and polarity helper for the wire TX path
package usb_wire_pkg;

  typedef enum logic [1:0] {
    SYM_SE0 = 2'b00,
    SYM_J   = 2'b01,
    SYM_K   = 2'b10,
    SYM_RSV = 2'b11
  } usb_sym_e;

  localparam int FS_DIV_DEFAULT = 4;
  localparam int LS_DIV_DEFAULT = 32;

  typedef struct packed {
    logic       oe;
    logic [1:0] data;
  } tx_entry_t;

  localparam int FIFO_ENTRY_W = $bits(tx_entry_t);

  // Returns {dp, dm}; the reserved code drives SE0.
  function automatic logic [1:0] line_drive(input logic [1:0] sym, input logic pol);
    case (sym)
      SYM_J:   line_drive = {pol, ~pol};
      SYM_K:   line_drive = {~pol, pol};
      default: line_drive = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/usb_wire_tx_fifo.sv
// rtl/usb_wire_tx_fifo.sv - synchronous symbol FIFO with full/empty/count, shared with the slave TX path
module usb_wire_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             do_wr;
  logic             do_rd;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_wr     = wr_en_i & ~full_o;
  assign do_rd     = rd_en_i & ~empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_comb begin
    count_d = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + CW'(1);
    end else if (do_rd && !do_wr) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/usb_wire_tx_pacer.sv
// rtl/usb_wire_tx_pacer.sv - paces buffered line symbols onto D+/D- at FS/LS rate; option USB_WIRE_TX_UNDERRUN_EN
module usb_wire_tx_pacer
  import usb_wire_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FS_DIV     = FS_DIV_DEFAULT,
  parameter int LS_DIV     = LS_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sym_data,
  input  logic       sym_oe,
  input  logic       sym_valid,
  output logic       sym_ready,
  input  logic       fullSpeedRate,
  input  logic       fullSpeedPol,
  output logic       usb_dp,
  output logic       usb_dm,
  output logic       usb_oe,
  output logic       tx_idle,
  output logic       tx_underrun
);

  localparam int CNT_W = $clog2(LS_DIV);
  localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;

  tx_entry_t        wr_entry;
  tx_entry_t        rd_entry;
  logic [FIFO_ENTRY_W-1:0] rd_raw;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FC_W-1:0]  fifo_count;

  logic [CNT_W-1:0] bit_cnt_q;
  logic [CNT_W-1:0] bit_cnt_d;
  logic [CNT_W-1:0] reload;
  logic             tick;
  logic             pop;
  logic             usb_dp_q;
  logic             usb_dm_q;
  logic             usb_oe_q;

  assign wr_entry = '{oe: sym_oe, data: sym_data};
  assign rd_entry = tx_entry_t'(rd_raw);

  usb_wire_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_ENTRY_W)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (sym_valid),
    .wr_data_i (wr_entry),
    .rd_en_i   (pop),
    .rd_data_o (rd_raw),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // The divisor is latched only at reload, so a rate change never stretches the bit in flight.
  assign reload = fullSpeedRate ? CNT_W'(FS_DIV - 1) : CNT_W'(LS_DIV - 1);
  assign tick   = (bit_cnt_q == '0);
  assign pop    = tick & ~fifo_empty;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (pop) begin
      bit_cnt_d = reload;
    end else if (!tick) begin
      bit_cnt_d = bit_cnt_q - CNT_W'(1);
    end
  end

`ifdef USB_WIRE_TX_UNDERRUN_EN
  logic underrun_q;
  assign tx_underrun = underrun_q;
`else
  assign tx_underrun = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= '0;
      usb_dp_q  <= 1'b0;
      usb_dm_q  <= 1'b0;
      usb_oe_q  <= 1'b0;
`ifdef USB_WIRE_TX_UNDERRUN_EN
      underrun_q <= 1'b0;
`endif
    end else begin
      bit_cnt_q <= bit_cnt_d;
      if (pop) begin
        {usb_dp_q, usb_dm_q} <= line_drive(rd_entry.data, fullSpeedPol);
        usb_oe_q             <= rd_entry.oe;
      end
`ifdef USB_WIRE_TX_UNDERRUN_EN
      // Starved mid-packet: release the bus rather than stretch the last symbol.
      else if (tick && usb_oe_q) begin
        underrun_q <= 1'b1;
        usb_oe_q   <= 1'b0;
        usb_dp_q   <= 1'b0;
        usb_dm_q   <= 1'b0;
      end
`endif
    end
  end

  assign usb_dp    = usb_dp_q;
  assign usb_dm    = usb_dm_q;
  assign usb_oe    = usb_oe_q;
  assign sym_ready = ~fifo_full;
  assign tx_idle   = (fifo_count == '0) & tick;

endmodule
